// File: rtl/fb_scan_arbiter_pkg.sv
// Shared constants and types for the frame-buffer scan-out / plotter arbiter.
package fb_scan_arbiter_pkg;

    localparam int unsigned FB_W       = 200;
    localparam int unsigned FB_H       = 120;
    localparam int unsigned SCALE_LOG2 = 2;
    localparam int unsigned ADDR_W     = 15;
    localparam int unsigned FB_DEPTH   = FB_W * FB_H;

    // pix_x value two pixels before the start of each line (wrapped negative)
    localparam logic [15:0] LINE_PREFETCH_X = 16'hFFFE;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        CLEAR
    } clear_state_t;

endpackage

// File: rtl/fb_scan_arbiter_if.sv
// Plotter write handshake plus single-port RAM bus; slave is the arbiter side,
// master is the surrounding system (plotter source and RAM).
interface fb_scan_arbiter_if #(
    parameter int unsigned ADDR_W = 15
);
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;

    modport master (
        output wr_valid, wr_addr, wr_data, mem_rdata,
        input  wr_ready, mem_addr, mem_we, mem_wdata
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data, mem_rdata,
        output wr_ready, mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/fb_scan_arbiter_clear_fsm.sv
// Frame-synchronous clear sweep: arms on request, zeroes the buffer in free RAM slots.
module fb_clear_fsm
    import fb_scan_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH  = FB_DEPTH,
    parameter int unsigned ADDR_W = 15
) (
    input  logic              PixelClk,
    input  logic              nRST,
    input  logic              clear_req,
    input  logic              frame_start,
    input  logic              slot_free,
    output logic              busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    clear_state_t      state;
    clear_state_t      state_nxt;
    logic [ADDR_W-1:0] cnt;

    always_ff @(posedge PixelClk or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (clr_we) begin
                cnt <= (cnt == LAST_ADDR) ? '0 : cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (clear_req)   state_nxt = ARMED;
            ARMED: if (frame_start) state_nxt = CLEAR;
            CLEAR: if (slot_free && cnt == LAST_ADDR) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy     = (state != IDLE);
        clr_we   = (state == CLEAR) && slot_free;
        clr_addr = cnt;
    end

endmodule

// File: rtl/fb_scan_arbiter.sv
// Single-port frame-buffer arbiter: prefetched LCD scan-out reads take priority over
// the clear sweep, which takes priority over plotter writes.
module fb_scan_arbiter #(
    parameter int unsigned FB_W       = fb_scan_arbiter_pkg::FB_W,
    parameter int unsigned FB_H       = fb_scan_arbiter_pkg::FB_H,
    parameter int unsigned SCALE_LOG2 = fb_scan_arbiter_pkg::SCALE_LOG2,
    parameter int unsigned ADDR_W     = fb_scan_arbiter_pkg::ADDR_W
) (
    input  logic        PixelClk,
    input  logic        nRST,
    input  logic [15:0] pix_x,
    input  logic [15:0] pix_y,
    input  logic        pix_valid,
    output logic [7:0]  pix_data,
    input  logic        clear_req,
    output logic        clear_busy,
    fb_scan_arbiter_if.slave bus
);
    import fb_scan_arbiter_pkg::*;

    localparam int unsigned DEPTH  = FB_W * FB_H;
    localparam int unsigned SUB_PF = (1 << SCALE_LOG2) - 2;

    logic [15:0]           col;
    logic [15:0]           row;
    logic [15:0]           tgt;
    logic [SCALE_LOG2-1:0] sub;
    logic                  line_pf;
    logic                  disp_rd;
    logic                  blank;
    logic [ADDR_W-1:0]     rd_addr;
    logic                  rd_pending;
    logic                  blank_q;
    logic                  frame_start;
    logic                  clr_busy;
    logic                  clr_we;
    logic [ADDR_W-1:0]     clr_addr;

    // Reads are issued two pixels ahead so the data lands on the first pixel of the column.
    always_comb begin
        col      = pix_x >> SCALE_LOG2;
        row      = pix_y >> SCALE_LOG2;
        sub      = pix_x[SCALE_LOG2-1:0];
        line_pf  = (pix_x == LINE_PREFETCH_X);
        disp_rd  = line_pf || (sub == SCALE_LOG2'(SUB_PF));
        tgt      = line_pf ? 16'd0 : col + 16'd1;
        blank    = (row >= 16'(FB_H)) || (tgt >= 16'(FB_W));
        rd_addr  = ADDR_W'(ADDR_W'(row) * ADDR_W'(FB_W)) + ADDR_W'(tgt);
        frame_start = pix_valid && (pix_x == 16'd0) && (pix_y == 16'd0);
    end

    fb_clear_fsm #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_clear (
        .PixelClk    (PixelClk),
        .nRST        (nRST),
        .clear_req   (clear_req),
        .frame_start (frame_start),
        .slot_free   (!disp_rd),
        .busy        (clr_busy),
        .clr_we      (clr_we),
        .clr_addr    (clr_addr)
    );

    assign clear_busy = clr_busy;

    // A blanked display slot owns the cycle but leaves the RAM idle.
    always_comb begin
        bus.mem_addr  = '0;
        bus.mem_we    = 1'b0;
        bus.mem_wdata = '0;
        bus.wr_ready  = !disp_rd && !clr_busy;
        if (disp_rd) begin
            if (!blank) begin
                bus.mem_addr = rd_addr;
            end
        end else if (clr_we) begin
            bus.mem_addr = clr_addr;
            bus.mem_we   = 1'b1;
        end else if (bus.wr_valid && bus.wr_ready && (32'(bus.wr_addr) < 32'(DEPTH))) begin
            bus.mem_addr  = bus.wr_addr;
            bus.mem_we    = 1'b1;
            bus.mem_wdata = bus.wr_data;
        end
    end

    always_ff @(posedge PixelClk or negedge nRST) begin
        if (!nRST) begin
            rd_pending <= 1'b0;
            blank_q    <= 1'b0;
            pix_data   <= '0;
        end else begin
            rd_pending <= disp_rd;
            blank_q    <= blank;
            if (rd_pending) begin
                pix_data <= blank_q ? 8'd0 : bus.mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_fb_scan_arbiter.sv
// Directed bench for fb_scan_arbiter with a behavioural 1-cycle-latency RAM.
module tb_fb_scan_arbiter;

    logic        PixelClk = 1'b0;
    logic        nRST;
    logic [15:0] pix_x;
    logic [15:0] pix_y;
    logic        pix_valid;
    logic [7:0]  pix_data;
    logic        clear_req;
    logic        clear_busy;
    logic        preload_en;
    logic [7:0]  ram [0:32767];

    int checks = 0;
    int errors = 0;

    fb_scan_arbiter_if #(.ADDR_W(15)) bus ();

    fb_scan_arbiter #(
        .FB_W       (200),
        .FB_H       (120),
        .SCALE_LOG2 (2),
        .ADDR_W     (15)
    ) dut (
        .PixelClk   (PixelClk),
        .nRST       (nRST),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .pix_valid  (pix_valid),
        .pix_data   (pix_data),
        .clear_req  (clear_req),
        .clear_busy (clear_busy),
        .bus        (bus)
    );

    always #5 PixelClk = ~PixelClk;

    always @(posedge PixelClk) begin
        if (preload_en) begin
            for (int k = 0; k < 32768; k++) ram[k] <= (k < 24000) ? 8'(k) : 8'h00;
        end else if (bus.mem_we) begin
            ram[bus.mem_addr] <= bus.mem_wdata;
        end
        bus.mem_rdata <= ram[bus.mem_addr];
    end

    // Drive one pixel position just after the edge, return at the sampling (falling) edge.
    task automatic step(input int x, input int y, input logic v);
        @(posedge PixelClk);
        #1;
        pix_x     = 16'(x);
        pix_y     = 16'(y);
        pix_valid = v;
        @(negedge PixelClk);
    endtask

    task automatic test_reset();
        nRST = 1'b0; pix_x = 16'd0; pix_y = 16'd0; pix_valid = 1'b0; clear_req = 1'b0;
        bus.wr_valid = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; preload_en = 1'b0;
        repeat (3) @(negedge PixelClk);
        checks++; if (pix_data !== 8'h00) begin errors++; $display("FAIL reset_pix_data got %0h exp 0", pix_data); end
        checks++; if (clear_busy !== 1'b0) begin errors++; $display("FAIL reset_clear_busy got %0b exp 0", clear_busy); end
        checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we got %0b exp 0", bus.mem_we); end
        checks++; if (bus.wr_ready !== 1'b1) begin errors++; $display("FAIL reset_wr_ready got %0b exp 1", bus.wr_ready); end
        #1 nRST = 1'b1;
    endtask

    task automatic test_scan();
        logic [7:0] exp;
        @(posedge PixelClk); #1 preload_en = 1'b1;
        @(posedge PixelClk); #1 preload_en = 1'b0;
        for (int x = -4; x < 800; x++) begin
            step(x, 0, x >= 0);
            exp = 8'(x >> 2);
            if (x >= 0) begin
                checks++;
                if (pix_data !== exp) begin errors++; $display("FAIL scan_row0 x=%0d got %0h exp %0h", x, pix_data, exp); end
            end
        end
        for (int x = -2; x <= 40; x++) begin
            step(x, 20, x >= 0);
            exp = 8'(1000 + (x >> 2));
            if (x >= 0) begin
                checks++;
                if (pix_data !== exp) begin errors++; $display("FAIL scan_row5 x=%0d got %0h exp %0h", x, pix_data, exp); end
            end
        end
    endtask

    task automatic test_blank_rows();
        for (int x = -2; x <= 20; x++) begin
            step(x, 480, x >= 0);
            checks++;
            if (x < 0) begin
                if (pix_data !== 8'hF2) begin errors++; $display("FAIL blank_hold x=%0d got %0h exp f2", x, pix_data); end
            end else if (pix_data !== 8'h00) begin
                errors++; $display("FAIL blank_zero x=%0d got %0h exp 0", x, pix_data);
            end
            checks++;
            if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL blank_mem_we x=%0d got %0b exp 0", x, bus.mem_we); end
        end
    endtask

    task automatic test_write();
        logic exp_rdy;
        bus.wr_valid = 1'b1; bus.wr_addr = 15'd5; bus.wr_data = 8'hAA;
        for (int x = -2; x < 40; x++) begin
            step(x, 0, x >= 0);
            exp_rdy = ((x & 3) != 2);
            checks++;
            if (bus.wr_ready !== exp_rdy) begin errors++; $display("FAIL wr_ready x=%0d got %0b exp %0b", x, bus.wr_ready, exp_rdy); end
            checks++;
            if (bus.mem_we !== exp_rdy) begin errors++; $display("FAIL wr_mem_we x=%0d got %0b exp %0b", x, bus.mem_we, exp_rdy); end
        end
        bus.wr_valid = 1'b0;
        @(negedge PixelClk);
        checks++; if (ram[5] !== 8'hAA) begin errors++; $display("FAIL wr_landed got %0h exp aa", ram[5]); end
        for (int x = -2; x < 24; x++) begin
            step(x, 0, x >= 0);
            if (x >= 16) begin
                checks++;
                if (x >= 20 && pix_data !== 8'hAA) begin errors++; $display("FAIL wr_display x=%0d got %0h exp aa", x, pix_data); end
                if (x < 20 && pix_data !== 8'h04) begin errors++; $display("FAIL wr_display x=%0d got %0h exp 4", x, pix_data); end
            end
        end
    endtask

    task automatic test_oob_write();
        step(1, 0, 1'b1);
        bus.wr_valid = 1'b1; bus.wr_addr = 15'd24000; bus.wr_data = 8'h77;
        #1;
        checks++; if (bus.wr_ready !== 1'b1) begin errors++; $display("FAIL oob_ready got %0b exp 1", bus.wr_ready); end
        checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL oob_mem_we got %0b exp 0", bus.mem_we); end
        bus.wr_addr = 15'd23999; bus.wr_data = 8'h5A;
        #1;
        checks++; if (bus.mem_we !== 1'b1) begin errors++; $display("FAIL last_mem_we got %0b exp 1", bus.mem_we); end
        checks++; if (bus.mem_addr !== 15'd23999) begin errors++; $display("FAIL last_addr got %0d exp 23999", bus.mem_addr); end
        step(1, 0, 1'b1);
        bus.wr_valid = 1'b0;
        checks++; if (ram[23999] !== 8'h5A) begin errors++; $display("FAIL last_landed got %0h exp 5a", ram[23999]); end
    endtask

    task automatic test_clear();
        int  x;
        int  exp_addr = 0;
        bit  done = 0;
        step(300, 100, 1'b1);
        bus.wr_valid = 1'b1; bus.wr_addr = 15'd7; bus.wr_data = 8'h33; clear_req = 1'b1;
        #1;
        checks++; if (bus.mem_we !== 1'b1 || bus.mem_addr !== 15'd7) begin
            errors++; $display("FAIL clr_simul_write we=%0b addr=%0d exp we=1 addr=7", bus.mem_we, bus.mem_addr); end
        step(301, 100, 1'b1);
        clear_req = 1'b0; bus.wr_addr = 15'd9; bus.wr_data = 8'h11;
        checks++; if (ram[7] !== 8'h33) begin errors++; $display("FAIL clr_simul_landed got %0h exp 33", ram[7]); end
        checks++; if (clear_busy !== 1'b1) begin errors++; $display("FAIL clr_busy_armed got %0b exp 1", clear_busy); end
        for (int xx = 302; xx <= 800; xx++) begin
            if (xx < 800) step(xx, 100, 1'b1); else step(0, 0, 1'b0);
            checks++;
            if (bus.mem_we !== 1'b0 || bus.wr_ready !== 1'b0 || clear_busy !== 1'b1) begin
                errors++; $display("FAIL clr_armed x=%0d we=%0b rdy=%0b busy=%0b exp 0 0 1", xx, bus.mem_we, bus.wr_ready, clear_busy); end
        end
        step(0, 0, 1'b1);
        checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL clr_frame_start_we got %0b exp 0", bus.mem_we); end
        for (int n = 1; n <= 40000 && !done; n++) begin
            x = n % 1000;
            if (x >= 800) x -= 1000;
            step(x, n / 1000, 1'b1);
            if (!clear_busy) begin
                done = 1;
            end else begin
                if (n == 1) begin
                    checks++;
                    if (bus.mem_we !== 1'b1 || bus.mem_addr !== 15'd0) begin
                        errors++; $display("FAIL clr_first we=%0b addr=%0d exp 1 0", bus.mem_we, bus.mem_addr); end
                end
                checks++;
                if (bus.wr_ready !== 1'b0) begin errors++; $display("FAIL clr_wr_ready n=%0d got %0b exp 0", n, bus.wr_ready); end
                if (bus.mem_we) begin
                    checks++;
                    if (bus.mem_addr !== 15'(exp_addr) || bus.mem_wdata !== 8'h00) begin
                        errors++; $display("FAIL clr_seq addr=%0d data=%0h exp %0d 0", bus.mem_addr, bus.mem_wdata, exp_addr); end
                    exp_addr++;
                end
            end
        end
        bus.wr_valid = 1'b0;
        checks++; if (!done) begin errors++; $display("FAIL clr_timeout busy=%0b exp 0", clear_busy); end
        checks++; if (exp_addr != 24000) begin errors++; $display("FAIL clr_count got %0d exp 24000", exp_addr); end
        begin
            int nz = 0;
            for (int k = 0; k < 24000; k++) if (ram[k] !== 8'h00) nz++;
            checks++; if (nz != 0) begin errors++; $display("FAIL clr_ram_nonzero got %0d exp 0", nz); end
        end
    endtask

    task automatic test_reset_mid_sweep();
        step(5, 3, 1'b1);
        clear_req = 1'b1;
        step(6, 3, 1'b1);
        clear_req = 1'b0;
        step(0, 0, 1'b1);
        for (int x = 1; x <= 49; x++) step(x, 0, 1'b1);
        checks++; if (bus.mem_we !== 1'b1 || clear_busy !== 1'b1) begin
            errors++; $display("FAIL mid_sweep_active we=%0b busy=%0b exp 1 1", bus.mem_we, clear_busy); end
        nRST = 1'b0;
        #1;
        checks++; if (clear_busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %0b exp 0", clear_busy); end
        checks++; if (pix_data !== 8'h00) begin errors++; $display("FAIL rst_mid_pix got %0h exp 0", pix_data); end
        checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL rst_mid_we got %0b exp 0", bus.mem_we); end
        @(negedge PixelClk);
        #1 nRST = 1'b1;
        for (int x = 51; x <= 60; x++) begin
            step(x, 0, 1'b1);
            checks++;
            if (bus.mem_we !== 1'b0 || clear_busy !== 1'b0) begin
                errors++; $display("FAIL rst_no_resume x=%0d we=%0b busy=%0b exp 0 0", x, bus.mem_we, clear_busy); end
        end
        clear_req = 1'b1;
        step(61, 0, 1'b1);
        clear_req = 1'b0;
        step(0, 0, 1'b1);
        step(1, 0, 1'b1);
        checks++; if (bus.mem_we !== 1'b1 || bus.mem_addr !== 15'd0) begin
            errors++; $display("FAIL rst_restart we=%0b addr=%0d exp 1 0", bus.mem_we, bus.mem_addr); end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_blank_rows();
        test_write();
        test_oob_write();
        test_clear();
        test_reset_mid_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
